mem_port_arbiter: RTL and testbench

- Shares one read/write port of the ideal memory between two requesters: the instruction-fetch master (read-only) and the data master (read/write).
- Arbitration is round-robin. Each master sees a request/ready handshake plus a registered read-response channel with its own backpressure.
- Sits between the MIPS core's fetch and load/store logic and the memory's Waddr/Raddr1/Wren/Rden1/Wdata/Rdata1 port.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter_resp_buffer.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 77 +++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master memory port arbiter.
//   GNT_INST / GNT_DATA : encoding of the last_grant register
//   rb_state_t          : response-buffer occupancy state
package mem_port_arbiter_pkg;

   localparam logic GNT_INST = 1'b0;
   localparam logic GNT_DATA = 1'b1;

   typedef enum logic {
      RB_EMPTY = 1'b0,
      RB_FULL  = 1'b1
   } rb_state_t;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data masters, the arbiter and the memory port.
//   inst_*  : fetch master request/ready plus read-response channel
//   data_*  : data master request/ready (read or write) plus read-response channel
//   mem_*   : single read/write port of the ideal memory (asynchronous read)
// Modports:
//   slave  : the arbiter's view
//   master : the masters' and memory's view (testbench side)
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 14
);

   localparam int AW = ADDR_WIDTH - 2;

   logic          inst_req;
   logic [AW-1:0] inst_addr;
   logic          inst_ready;
   logic          inst_rvalid;
   logic [31:0]   inst_rdata;
   logic          inst_rready;

   logic          data_req;
   logic          data_wen;
   logic [AW-1:0] data_addr;
   logic [31:0]   data_wdata;
   logic          data_ready;
   logic          data_rvalid;
   logic [31:0]   data_rdata;
   logic          data_rready;

   logic [AW-1:0] mem_Waddr;
   logic [AW-1:0] mem_Raddr;
   logic          mem_Wren;
   logic          mem_Rden;
   logic [31:0]   mem_Wdata;
   logic [31:0]   mem_Rdata;

   modport slave (
      input  inst_req, inst_addr, inst_rready,
      input  data_req, data_wen, data_addr, data_wdata, data_rready,
      input  mem_Rdata,
      output inst_ready, inst_rvalid, inst_rdata,
      output data_ready, data_rvalid, data_rdata,
      output mem_Waddr, mem_Raddr, mem_Wren, mem_Rden, mem_Wdata
   );

   modport master (
      output inst_req, inst_addr, inst_rready,
      output data_req, data_wen, data_addr, data_wdata, data_rready,
      output mem_Rdata,
      input  inst_ready, inst_rvalid, inst_rdata,
      input  data_ready, data_rvalid, data_rdata,
      input  mem_Waddr, mem_Raddr, mem_Wren, mem_Rden, mem_Wdata
   );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_resp_buffer.sv
// One-entry registered read-response buffer for a single master.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   load        : accepted read this cycle; capture load_data
//   load_data   : memory read data to capture
//   consume     : master takes the current response (ignored when empty)
//   valid, data : registered response outputs
//
// state    | meaning
// ---------+-------------------------------------------
// RB_EMPTY | no response held, valid=0
// RB_FULL  | response held in data, valid=1 until consumed
module mem_port_arbiter_resp_buffer
   import mem_port_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic        consume,
   output logic        valid,
   output logic [31:0] data
);

   rb_state_t state;

   // A load while FULL is only possible when consume is also high (the
   // arbiter blocks the read otherwise), so load simply overwrites.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= RB_EMPTY;
         valid <= 1'b0;
         data  <= '0;
      end else begin
         case (state)
            RB_EMPTY: begin
               if (load) begin
                  state <= RB_FULL;
                  valid <= 1'b1;
                  data  <= load_data;
               end
            end
            RB_FULL: begin
               if (load) begin
                  data <= load_data;
               end else if (consume) begin
                  state <= RB_EMPTY;
                  valid <= 1'b0;
               end
            end
            default: begin
               state <= RB_EMPTY;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : mem_port_arbiter_resp_buffer

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read/write port between the
// instruction-fetch master (read-only) and the data master (read/write).
// Ports:
//   clk    : core clock
//   resetn : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave -- both master channels and memory port
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  resetn,
   mem_port_arbiter_if.slave     bus
);

   logic                  last_grant;
   logic                  inst_elig;
   logic                  data_elig;
   logic                  grant_inst;
   logic                  grant_data;
   logic                  inst_load;
   logic                  data_load;
   logic [ADDR_WIDTH-3:0] rd_addr;

   // A read needs a free (or draining) response slot; writes never do.
   always_comb begin
      inst_elig  = bus.inst_req & ~(bus.inst_rvalid & ~bus.inst_rready);
      data_elig  = bus.data_req & (bus.data_wen | ~(bus.data_rvalid & ~bus.data_rready));
      // resetn gating keeps the memory port idle while held in reset.
      grant_inst = resetn & inst_elig & (~data_elig | (last_grant == GNT_DATA));
      grant_data = resetn & data_elig & (~inst_elig | (last_grant == GNT_INST));
      inst_load  = grant_inst;
      data_load  = grant_data & ~bus.data_wen;
      rd_addr    = grant_data ? bus.data_addr : bus.inst_addr;
   end

   assign bus.inst_ready = grant_inst;
   assign bus.data_ready = grant_data;
   assign bus.mem_Raddr  = rd_addr;
   assign bus.mem_Waddr  = bus.data_addr;
   assign bus.mem_Wdata  = bus.data_wdata;
   assign bus.mem_Rden   = inst_load | data_load;
   assign bus.mem_Wren   = grant_data & bus.data_wen;

   // Reset to DATA so the fetch master wins the first contention.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_grant <= GNT_DATA;
      end else if (grant_inst) begin
         last_grant <= GNT_INST;
      end else if (grant_data) begin
         last_grant <= GNT_DATA;
      end
   end

   mem_port_arbiter_resp_buffer u_inst_buf (
      .clk       (clk),
      .resetn    (resetn),
      .load      (inst_load),
      .load_data (bus.mem_Rdata),
      .consume   (bus.inst_rready),
      .valid     (bus.inst_rvalid),
      .data      (bus.inst_rdata)
   );

   mem_port_arbiter_resp_buffer u_data_buf (
      .clk       (clk),
      .resetn    (resetn),
      .load      (data_load),
      .load_data (bus.mem_Rdata),
      .consume   (bus.data_rready),
      .valid     (bus.data_rvalid),
      .data      (bus.data_rdata)
   );

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int ADDR_WIDTH = 14;
   localparam int AW         = ADDR_WIDTH - 2;
   localparam int DEPTH      = 1 << AW;

   logic clk;
   logic resetn;

   mem_port_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

   mem_port_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory seen by the DUT, and the reference copy the model keeps.
   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   function automatic logic [31:0] init_word(input int i);
      return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (bus.mem_Wren) mem[bus.mem_Waddr] = bus.mem_Wdata;
      end
   end

   assign bus.mem_Rdata = mem[bus.mem_Raddr];

   int n_vectors = 0;
   int n_checks  = 0;
   int n_errors  = 0;

   // Reference model state: pending-response flags, expected responses,
   // and which master was served most recently.
   bit          inst_pend, data_pend;
   bit          last_was_data;
   logic [31:0] inst_q[$];
   logic [31:0] data_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      inst_pend     = 1'b0;
      data_pend     = 1'b0;
      last_was_data = 1'b1;
      inst_q.delete();
      data_q.delete();
   endtask

   task automatic chk_reset_outputs();
      chk("rst_inst_ready",  {31'b0, bus.inst_ready},  32'd0);
      chk("rst_data_ready",  {31'b0, bus.data_ready},  32'd0);
      chk("rst_mem_wren",    {31'b0, bus.mem_Wren},    32'd0);
      chk("rst_mem_rden",    {31'b0, bus.mem_Rden},    32'd0);
      chk("rst_inst_rvalid", {31'b0, bus.inst_rvalid}, 32'd0);
      chk("rst_data_rvalid", {31'b0, bus.data_rvalid}, 32'd0);
      chk("rst_inst_rdata",  bus.inst_rdata, 32'd0);
      chk("rst_data_rdata",  bus.data_rdata, 32'd0);
   endtask

   // Called at posedge+1; asserts reset mid-cycle and holds it n cycles.
   task automatic reset_pulse(input int n);
      resetn = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs();
      repeat (n) begin
         @(negedge clk);
         chk_reset_outputs();
         @(posedge clk);
         #1;
      end
      resetn = 1'b1;
   endtask

   // One cycle of stimulus; the model predicts grants and memory drive.
   task automatic step(input logic ireq, input logic [AW-1:0] iaddr, input logic irr,
                       input logic dreq, input logic dwen, input logic [AW-1:0] daddr,
                       input logic [31:0] wd, input logic drr);
      bit ie, de, gi, gd, rd;
      bus.inst_req    = ireq;
      bus.inst_addr   = iaddr;
      bus.inst_rready = irr;
      bus.data_req    = dreq;
      bus.data_wen    = dwen;
      bus.data_addr   = daddr;
      bus.data_wdata  = wd;
      bus.data_rready = drr;
      n_vectors++;
      @(negedge clk);
      ie = ireq && !(inst_pend && !irr);
      de = dreq && (dwen || !(data_pend && !drr));
      if (ie && de) begin
         gi = last_was_data;
         gd = !last_was_data;
      end else begin
         gi = ie;
         gd = de;
      end
      rd = gi || (gd && !dwen);
      chk("inst_ready",  {31'b0, bus.inst_ready},  {31'b0, gi});
      chk("data_ready",  {31'b0, bus.data_ready},  {31'b0, gd});
      chk("mem_rden",    {31'b0, bus.mem_Rden},    {31'b0, rd});
      chk("mem_wren",    {31'b0, bus.mem_Wren},    {31'b0, gd && dwen});
      chk("inst_rvalid", {31'b0, bus.inst_rvalid}, {31'b0, inst_pend});
      chk("data_rvalid", {31'b0, bus.data_rvalid}, {31'b0, data_pend});
      if (gi) chk("mem_raddr_inst", {20'b0, bus.mem_Raddr}, {20'b0, iaddr});
      if (gd && !dwen) chk("mem_raddr_data", {20'b0, bus.mem_Raddr}, {20'b0, daddr});
      if (gd && dwen) begin
         chk("mem_waddr", {20'b0, bus.mem_Waddr}, {20'b0, daddr});
         chk("mem_wdata", bus.mem_Wdata, wd);
         ref_mem[daddr] = wd;
      end
      if (gi) begin
         inst_q.push_back(ref_mem[iaddr]);
         inst_pend = 1'b1;
      end else if (irr) begin
         inst_pend = 1'b0;
      end
      if (gd && !dwen) begin
         data_q.push_back(ref_mem[daddr]);
         data_pend = 1'b1;
      end else if (drr) begin
         data_pend = 1'b0;
      end
      if (gi || gd) last_was_data = gd;
      @(posedge clk);
      #1;
   endtask

   // Response monitor: a presented response must match the oldest expected
   // one, and holds while backpressured.
   always @(negedge clk) begin
      if (resetn) begin
         if (bus.inst_rvalid) begin
            if (inst_q.size() == 0) chk("inst_resp_unexpected", 32'd1, 32'd0);
            else begin
               chk("inst_rdata", bus.inst_rdata, inst_q[0]);
               if (bus.inst_rready) void'(inst_q.pop_front());
            end
         end
         if (bus.data_rvalid) begin
            if (data_q.size() == 0) chk("data_resp_unexpected", 32'd1, 32'd0);
            else begin
               chk("data_rdata", bus.data_rdata, data_q[0]);
               if (bus.data_rready) void'(data_q.pop_front());
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      resetn = 1'b0;
      bus.inst_req = 0; bus.inst_addr = '0; bus.inst_rready = 0;
      bus.data_req = 0; bus.data_wen = 0; bus.data_addr = '0;
      bus.data_wdata = '0; bus.data_rready = 0;
      model_reset();
      @(negedge clk);
      chk_reset_outputs();
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Fetch-only streaming reads
      for (int i = 0; i < 4; i++) step(1, AW'(i), 1, 0, 0, '0, '0, 1);
      step(0, '0, 1, 0, 0, '0, '0, 1);

      // Contention from reset: fetch first, then alternate
      reset_pulse(1);
      for (int i = 0; i < 8; i++) step(1, AW'(5), 1, 1, 0, AW'(25), '0, 1);
      step(0, '0, 1, 0, 0, '0, '0, 1);

      // Write then read back
      step(0, '0, 1, 1, 1, AW'(30), 32'hDEADBEEF, 1);
      step(0, '0, 1, 1, 0, AW'(30), '0, 1);
      step(0, '0, 1, 0, 0, '0, '0, 1);

      // Fetch backpressure while data reads stream
      step(1, AW'(7), 0, 0, 0, '0, '0, 1);
      for (int i = 0; i < 4; i++) step(1, AW'(8), 0, 1, 0, AW'(40 + i), '0, 1);
      step(1, AW'(8), 1, 1, 0, AW'(44), '0, 1);
      step(0, '0, 1, 0, 0, '0, '0, 1);

      // Write while the data response buffer is full
      step(0, '0, 1, 1, 0, AW'(50), '0, 0);
      step(0, '0, 1, 1, 1, AW'(51), 32'h12345678, 0);
      step(0, '0, 1, 0, 0, '0, '0, 0);
      step(0, '0, 1, 1, 0, AW'(51), '0, 1);
      step(0, '0, 1, 0, 0, '0, '0, 1);

      // Reset in the middle of alternating traffic
      for (int i = 0; i < 3; i++) step(1, AW'(60), 1, 1, 0, AW'(61), '0, 1);
      step(1, AW'(60), 0, 1, 1, AW'(62), 32'hCAFEF00D, 0);
      reset_pulse(2);
      for (int i = 0; i < 4; i++) step(1, AW'(62), 1, 1, 0, AW'(62), '0, 1);

      // Randomized traffic over a small address window
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 499) == 0) reset_pulse($urandom_range(1, 2));
         step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 63)), $urandom_range(0, 9) < 7,
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, AW'($urandom_range(0, 63)),
              $urandom, $urandom_range(0, 9) < 7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter
